mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between two requesters: port 0 is the CPU
//  (ifetch and ldw/stw) and port 1 is a secondary master (loader/debug/DMA).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 18 +
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings,
// memory direction constants and the round-robin pointer update rule.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   // Wide enough for LATENCY-1 with LATENCY up to 15
   localparam int CNT_W = 4;

   function automatic logic nextPtr(input logic winner);
      return ~winner;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker; the pointer register lives in the parent.
module rr_arbiter2 (
   input  logic [1:0] iReq,
   input  logic       iPtr,
   output logic [1:0] oGnt
);

   // On contention the pointer decides: 0 favours port 0, 1 favours port 1
   always_comb begin
      oGnt = 2'b00;
      if (iReq == 2'b11) begin
         oGnt = iPtr ? 2'b10 : 2'b01;
      end else begin
         oGnt = iReq;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the CPU (port 0) and a secondary master
// (port 1) using round-robin arbitration and a fixed-latency access sequencer.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              iClk,
   input  logic              nRst,
   input  logic              iReq0,
   input  logic              iRW0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iWData0,
   output logic              oAck0,
   output logic [DATA_W-1:0] oRData0,
   input  logic              iReq1,
   input  logic              iRW1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iWData1,
   output logic              oAck1,
   output logic [DATA_W-1:0] oRData1,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemData,
   input  logic [DATA_W-1:0] iMemData,
   output logic              oMemRW,
   output logic              oMemEn,
   output logic              oBusy
);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ptr;
   logic                r_winner;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [DATA_W-1:0]   r_memData;
   logic                r_memRW;
   logic                r_memEn;
   logic                r_ack0;
   logic                r_ack1;
   logic [DATA_W-1:0]   r_rData0;
   logic [DATA_W-1:0]   r_rData1;
   logic [1:0]          w_gnt;

   rr_arbiter2 uArb (
      .iReq (iReq0 ? {iReq1, 1'b1} : {iReq1, 1'b0}),
      .iPtr (r_ptr),
      .oGnt (w_gnt)
   );

   // Single sequencer: the grant latches the winner's request, the counter paces
   // the access, and acks are one-cycle pulses cleared by default every cycle.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_ptr     <= 1'b0;
         r_winner  <= 1'b0;
         r_memAddr <= '0;
         r_memData <= '0;
         r_memRW   <= MEM_WRITE;
         r_memEn   <= 1'b0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_rData0  <= '0;
         r_rData1  <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt != 2'b00) begin
                  r_winner  <= w_gnt[1];
                  r_memRW   <= w_gnt[1] ? iRW1    : iRW0;
                  r_memAddr <= w_gnt[1] ? iAddr1  : iAddr0;
                  r_memData <= w_gnt[1] ? iWData1 : iWData0;
                  r_memEn   <= 1'b1;
                  r_cnt     <= CNT_W'(LATENCY - 1);
                  r_state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (r_cnt == '0) begin
                  if (r_memRW == MEM_READ) begin
                     if (r_winner) begin
                        r_rData1 <= iMemData;
                     end else begin
                        r_rData0 <= iMemData;
                     end
                  end
                  r_memEn <= 1'b0;
                  r_ack0  <= ~r_winner;
                  r_ack1  <= r_winner;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               r_ptr   <= nextPtr(r_winner);
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oAck0    = r_ack0;
   assign oAck1    = r_ack1;
   assign oRData0  = r_rData0;
   assign oRData1  = r_rData1;
   assign oMemAddr = r_memAddr;
   assign oMemData = r_memData;
   assign oMemRW   = r_memRW;
   assign oMemEn   = r_memEn;
   assign oBusy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at LATENCY=1 (a*) and one at
// LATENCY=3 (b*) share the same stimulus; each scenario checks the relevant instance.
module tb_mem_port_arbiter;

   logic        iClk = 1'b0;
   logic        nRst = 1'b1;
   logic        req0, rw0, req1, rw1;
   logic [31:0] addr0, wdata0, addr1, wdata1, memRData;

   logic        aAck0, aAck1, aMemRW, aMemEn, aBusy;
   logic [31:0] aRData0, aRData1, aMemAddr, aMemData;
   logic        bAck0, bAck1, bMemRW, bMemEn, bBusy;
   logic [31:0] bRData0, bRData1, bMemAddr, bMemData;

   int nChecks = 0;
   int nBad    = 0;
   int nAcks;
   int ackPort [4];
   int ackTime [4];

   always #5 iClk = ~iClk;

   mem_port_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dutA (
      .iClk(iClk), .nRst(nRst),
      .iReq0(req0), .iRW0(rw0), .iAddr0(addr0), .iWData0(wdata0), .oAck0(aAck0), .oRData0(aRData0),
      .iReq1(req1), .iRW1(rw1), .iAddr1(addr1), .iWData1(wdata1), .oAck1(aAck1), .oRData1(aRData1),
      .oMemAddr(aMemAddr), .oMemData(aMemData), .iMemData(memRData),
      .oMemRW(aMemRW), .oMemEn(aMemEn), .oBusy(aBusy)
   );

   mem_port_arbiter #(.LATENCY(3), .ADDR_W(32), .DATA_W(32)) dutB (
      .iClk(iClk), .nRst(nRst),
      .iReq0(req0), .iRW0(rw0), .iAddr0(addr0), .iWData0(wdata0), .oAck0(bAck0), .oRData0(bRData0),
      .iReq1(req1), .iRW1(rw1), .iAddr1(addr1), .iWData1(wdata1), .oAck1(bAck1), .oRData1(bRData1),
      .oMemAddr(bMemAddr), .oMemData(bMemData), .iMemData(memRData),
      .oMemRW(bMemRW), .oMemEn(bMemEn), .oBusy(bBusy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                input logic r1, input logic w1, input logic [31:0] a1);
      req0  = r0;
      rw0   = w0;
      addr0 = a0;
      req1  = r1;
      rw1   = w1;
      addr1 = a1;
   endtask

   task automatic applyReset();
      nRst     = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      wdata0   = 32'h0;
      wdata1   = 32'h0;
      memRData = 32'h0;
      repeat (2) @(negedge iClk);
      checkOutput("rst bMemEn", bMemEn, 0);
      checkOutput("rst bMemAddr", bMemAddr, 0);
      checkOutput("rst bMemData", bMemData, 0);
      checkOutput("rst bMemRW", bMemRW, 0);
      checkOutput("rst bAcks", {bAck1, bAck0}, 0);
      checkOutput("rst bRData0", bRData0, 0);
      checkOutput("rst bRData1", bRData1, 0);
      checkOutput("rst bBusy", bBusy, 0);
      checkOutput("rst aMemEn", aMemEn, 0);
      nRst = 1'b1;
      @(negedge iClk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      #1;
      applyReset();

      // Port 0 read, LATENCY=1
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      memRData = 32'hDEADBEEF;
      @(negedge iClk);
      checkOutput("t1 en", aMemEn, 1);
      checkOutput("t1 rw", aMemRW, 1);
      checkOutput("t1 addr", aMemAddr, 32'h100);
      checkOutput("t1 ack0 early", aAck0, 0);
      @(negedge iClk);
      checkOutput("t1 en off", aMemEn, 0);
      checkOutput("t1 ack0", aAck0, 1);
      checkOutput("t1 ack1", aAck1, 0);
      checkOutput("t1 rdata0", aRData0, 32'hDEADBEEF);
      req0 = 1'b0;
      @(negedge iClk);
      checkOutput("t1 ack0 pulse", aAck0, 0);
      checkOutput("t1 rdata0 hold", aRData0, 32'hDEADBEEF);
      checkOutput("t1 busy", aBusy, 0);

      // Port 1 write, LATENCY=3
      applyReset();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20);
      wdata1 = 32'h12345678;
      for (int k = 1; k <= 3; k++) begin
         @(negedge iClk);
         checkOutput("t2 en", bMemEn, 1);
         checkOutput("t2 rw", bMemRW, 0);
         checkOutput("t2 addr", bMemAddr, 32'h20);
         checkOutput("t2 data", bMemData, 32'h12345678);
         checkOutput("t2 ack1 early", bAck1, 0);
      end
      @(negedge iClk);
      checkOutput("t2 en off", bMemEn, 0);
      checkOutput("t2 ack1", bAck1, 1);
      checkOutput("t2 ack0", bAck0, 0);
      checkOutput("t2 rdata1", bRData1, 0);
      req1 = 1'b0;
      @(negedge iClk);
      checkOutput("t2 ack1 pulse", bAck1, 0);

      // Both ports held: grants alternate 0,1,0,1 spaced LATENCY+2
      applyReset();
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
      nAcks = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge iClk);
         checkOutput("t3 bothAck", {63'b0, bAck0 & bAck1}, 0);
         if ((bAck0 | bAck1) && nAcks < 4) begin
            ackPort[nAcks] = bAck1 ? 1 : 0;
            ackTime[nAcks] = k;
            nAcks++;
         end
      end
      checkOutput("t3 ackCount", nAcks, 4);
      for (int i = 0; i < nAcks; i++) begin
         checkOutput("t3 ackPort", ackPort[i], i % 2);
         checkOutput("t3 ackTime", ackTime[i], 4 + 5 * i);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Address change during ACCESS is ignored
      applyReset();
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      memRData = 32'hCAFEF00D;
      for (int k = 1; k <= 3; k++) begin
         @(negedge iClk);
         checkOutput("t4 addr", bMemAddr, 32'h100);
         checkOutput("t4 en", bMemEn, 1);
         addr0 = 32'h200;
      end
      @(negedge iClk);
      checkOutput("t4 addr done", bMemAddr, 32'h100);
      checkOutput("t4 ack0", bAck0, 1);
      checkOutput("t4 rdata0", bRData0, 32'hCAFEF00D);
      req0 = 1'b0;
      @(negedge iClk);
      checkOutput("t4 ack0 pulse", bAck0, 0);

      // Pointer now favours port 1; reset mid-access re-serves with port 0 favoured
      applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h40);
      @(negedge iClk);
      checkOutput("t5 winner1 addr", bMemAddr, 32'h40);
      @(negedge iClk);
      nRst = 1'b0;
      #1;
      checkOutput("t5 rst en", bMemEn, 0);
      checkOutput("t5 rst addr", bMemAddr, 0);
      checkOutput("t5 rst acks", {bAck1, bAck0}, 0);
      checkOutput("t5 rst busy", bBusy, 0);
      checkOutput("t5 rst rdata0", bRData0, 0);
      checkOutput("t5 rst aEn", aMemEn, 0);
      @(negedge iClk);
      nRst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge iClk);
         checkOutput("t5 ack1", bAck1, 0);
         if (k == 1) checkOutput("t5 winner0 addr", bMemAddr, 32'h300);
         if (k == 4) checkOutput("t5 ack0", bAck0, 1);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Back-to-back port 0 reads: one IDLE cycle between accesses
      applyReset();
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 11; k++) begin
         @(negedge iClk);
         checkOutput("t6 busy", bBusy, (k % 5) != 0);
         checkOutput("t6 ack0", bAck0, (k % 5) == 4);
      end
      req0 = 1'b0;
      repeat (2) @(negedge iClk);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
